ps2_rx_fifo: RTL and testbench

- Parametrised successor to the single-byte PS/2 keyboard receiver used by the AVR system.
- Receives 11-bit PS/2 device-to-host frames with a glitch-filtered clock, odd-parity check, stop-bit check and inter-bit timeout.
- Buffers scancodes in a first-word-fall-through FIFO popped by the memory controller.
- Keeps a one-cycle hit strobe for existing consumers.

---
 rtl/ps2_rx_fifo_pkg.sv | 22 ++
 rtl/ps2_rx_fifo_sync_filter.sv | 60 ++++++
 rtl/ps2_rx_fifo.sv | 176 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: types, line levels and helpers shared by the PS/2 receive path.
//   ps2_state_t         frame decoder states
//   START_LVL/STOP_LVL  required data levels of the start and stop bits
//   ps2_timeout_cycles  inter-edge timeout in system clock cycles
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int unsigned ps2_timeout_cycles(input int unsigned clk_hz,
                                                     input int unsigned timeout_us);
    return (clk_hz / 32'd1000000) * timeout_us;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_filter.sv
// ps2_sync_filter: synchronises the raw PS/2 pins, glitch-filters the clock
// and emits a one-cycle strobe on each filtered falling edge.
//   clock, reset  system clock, async active-high reset
//   ps2_clk       raw PS/2 clock pin
//   ps2_dat       raw PS/2 data pin
//   fall          one-cycle pulse: filtered ps2_clk went 1 -> 0
//   dat_bit       synchronised ps2_dat captured with the falling edge
// Pin-to-fall latency is FILTER+2 cycles.
module ps2_sync_filter #(
  parameter int unsigned FILTER = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat_bit
);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       filt;
  logic [3:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // cnt tracks how many consecutive samples disagree with the filtered
  // level; the FILTER-th disagreeing sample commits the change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt    <= 1'b1;
      cnt     <= 4'd0;
      fall    <= 1'b0;
      dat_bit <= 1'b1;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != filt) begin
        if (cnt == 4'(FILTER - 1)) begin
          filt    <= clk_sync[1];
          cnt     <= 4'd0;
          fall    <= filt;
          dat_bit <= dat_sync[1];
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= 4'd0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with a first-word-fall-through
// scancode FIFO and sticky error flags.
//   clock, reset        system clock, async active-high reset
//   ps2_clk, ps2_dat    raw PS/2 pins
//   rd                  pop strobe (ignored when empty)
//   clr_err             clears overflow/perr/ferr
//   data                FIFO head byte, 0 when empty
//   valid               FIFO not empty
//   count               occupancy 0..DEPTH
//   hit                 one-cycle pulse per byte written into the FIFO
//   overflow/perr/ferr  sticky dropped-byte / parity / framing flags
//
// state  | meaning
// IDLE   | waiting for a start bit (dat=0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | latching odd-parity result
// STOP   | checking stop bit, requesting push or flagging the error
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FILTER     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ps2_clk,
  input  logic                       ps2_dat,
  input  logic                       rd,
  input  logic                       clr_err,
  output logic [7:0]                 data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       hit,
  output logic                       overflow,
  output logic                       perr,
  output logic                       ferr
);

  localparam int unsigned TO = ps2_timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int TW = $clog2(TO + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             fall;
  logic             dat_bit;
  ps2_state_t       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             parity_ok;
  logic [TW-1:0]    tmr;
  logic             push_req;
  logic [7:0]       push_byte;
  logic             timeout;
  logic             stop_evt;
  logic             ferr_evt;
  logic             perr_evt;

  ps2_sync_filter #(.FILTER(FILTER)) u_filter (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .fall    (fall),
    .dat_bit (dat_bit)
  );

  // Down-counter reloaded on each edge; an edge in the terminal cycle wins.
  assign timeout  = !fall && (state != IDLE) && (tmr == TW'(1));
  assign stop_evt = fall && (state == STOP);
  assign ferr_evt = (stop_evt && (dat_bit != STOP_LVL)) || timeout;
  assign perr_evt = stop_evt && !parity_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      parity_ok <= 1'b0;
      tmr       <= '0;
      push_req  <= 1'b0;
      push_byte <= 8'h00;
    end else begin
      push_req <= 1'b0;
      if (fall) begin
        tmr <= TW'(TO);
        case (state)
          IDLE: begin
            if (dat_bit == START_LVL) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {dat_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_ok <= (^shreg) ^ dat_bit;
            state     <= STOP;
          end
          STOP: begin
            if ((dat_bit == STOP_LVL) && parity_ok) begin
              push_req  <= 1'b1;
              push_byte <= shreg;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (timeout) state <= IDLE;
        else         tmr   <= tmr - TW'(1);
      end
    end
  end

  // FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          ovf_evt;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_req && (!full || do_pop);
  assign ovf_evt = push_req && full && !do_pop;

  assign valid = (count != '0);
  assign data  = valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hit    <= 1'b0;
    end else begin
      hit <= do_push;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: a new event outranks clr_err in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (perr_evt)     perr <= 1'b1;
      else if (clr_err) perr <= 1'b0;
      if (ferr_evt)     ferr <= 1'b1;
      else if (clr_err) ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames that should be accepted push the
// expected byte into exp_q; the monitor pops and compares on every rd that
// the DUT honours.
module tb_ps2_rx_fifo;

  localparam int CLK_HZ     = 25000000;
  localparam int DEPTH      = 16;
  localparam int TIMEOUT_US = 2000;
  localparam int FILTER     = 4;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          ps2_clk;
  logic          ps2_dat;
  logic          rd;
  logic          clr_err;
  logic [7:0]    data;
  logic          valid;
  logic [CW-1:0] count;
  logic          hit;
  logic          overflow;
  logic          perr;
  logic          ferr;

  ps2_rx_fifo #(
    .CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .TIMEOUT_US(TIMEOUT_US), .FILTER(FILTER)
  ) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd(rd), .clr_err(clr_err), .data(data), .valid(valid), .count(count),
    .hit(hit), .overflow(overflow), .perr(perr), .ferr(ferr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         hits   = 0;
  int         exp_hits = 0;
  logic [7:0] exp_q[$];

  // Monitor: compare every honoured pop against the scoreboard head.
  always @(negedge clock) begin
    logic [7:0] e;
    if (!reset) begin
      if (hit) hits++;
      if (rd && valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got=%h expected=none", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL pop_data got=%h expected=%h", data, e);
          end
        end
      end else if (rd) begin
        checks++;
        if (data !== 8'h00) begin
          errors++;
          $display("FAIL empty_data got=%h expected=00", data);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input int half);
    ps2_dat = b;
    step(half);
    ps2_clk = 1'b0;
    step(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input int half,
                            input logic accept);
    if (accept) begin
      exp_q.push_back(b);
      exp_hits++;
    end
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(b[i], half);
    send_bit((~^b) ^ bad_par, half);
    send_bit(~bad_stop, half);
    ps2_dat = 1'b1;
    step(half);
    step(4);
  endtask

  task automatic pop();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"},     int'(data), 0);
    chk({tag, "_valid"},    int'(valid), 0);
    chk({tag, "_count"},    int'(count), 0);
    chk({tag, "_hit"},      int'(hit), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_perr"},     int'(perr), 0);
    chk({tag, "_ferr"},     int'(ferr), 0);
  endtask

  initial begin
    reset   = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rd      = 1'b0;
    clr_err = 1'b0;
    step(3);
    chk_reset_vals("rst");
    reset = 1'b0;
    step(2);

    // Good 0x1C at a 2000-cycle bit period.
    send_frame(8'h1C, 1'b0, 1'b0, 1000, 1'b1);
    chk("t1_hits",  hits, exp_hits);
    chk("t1_valid", int'(valid), 1);
    chk("t1_data",  int'(data), 'h1C);
    chk("t1_count", int'(count), 1);
    pop();
    chk("t1_valid_after_rd", int'(valid), 0);
    chk("t1_data_after_rd",  int'(data), 0);
    pop();
    chk("rd_empty_count", int'(count), 0);

    // Bad parity.
    send_frame(8'h1C, 1'b1, 1'b0, 10, 1'b0);
    chk("t2_perr",  int'(perr), 1);
    chk("t2_ferr",  int'(ferr), 0);
    chk("t2_count", int'(count), 0);
    chk("t2_hits",  hits, exp_hits);
    pulse_clr();
    chk("t2_perr_clr", int'(perr), 0);

    // Bad stop bit.
    send_frame(8'h55, 1'b0, 1'b1, 10, 1'b0);
    chk("stop_ferr",  int'(ferr), 1);
    chk("stop_perr",  int'(perr), 0);
    chk("stop_count", int'(count), 0);
    pulse_clr();
    chk("stop_ferr_clr", int'(ferr), 0);

    // Timeout after four bits.
    send_bit(1'b0, 10);
    send_bit(1'b1, 10);
    send_bit(1'b0, 10);
    send_bit(1'b1, 10);
    step(50001);
    chk("to_ferr",  int'(ferr), 1);
    chk("to_count", int'(count), 0);
    pulse_clr();
    send_frame(8'hF0, 1'b0, 1'b0, 10, 1'b1);
    chk("to_next_data", int'(data), 'hF0);
    chk("to_next_ferr", int'(ferr), 0);
    pop();

    // Overflow: 17 frames into 16 entries.
    for (int i = 1; i <= 17; i++)
      send_frame(8'(i), 1'b0, 1'b0, 10, (i <= 16));
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag",  int'(overflow), 1);
    chk("ovf_head",  int'(data), 'h01);
    chk("ovf_hits",  hits, exp_hits);
    for (int i = 0; i < 16; i++) pop();
    chk("ovf_drained", int'(count), 0);
    pulse_clr();
    chk("ovf_clr", int'(overflow), 0);

    // Full FIFO: push cycle of frame 17 coincides with rd.
    for (int i = 1; i <= 16; i++)
      send_frame(8'(i), 1'b0, 1'b0, 10, 1'b1);
    fork
      send_frame(8'h11, 1'b0, 1'b0, 10, 1'b1);
      begin
        int n;
        n = 0;
        while (!dut.push_req && n < 600) begin
          step(1);
          n++;
        end
        if (n >= 600) begin
          checks++;
          errors++;
          $display("FAIL push_wait got=timeout expected=push_req");
        end else begin
          pop();
        end
      end
    join
    chk("fullrd_count",    int'(count), 16);
    chk("fullrd_overflow", int'(overflow), 0);
    chk("fullrd_head",     int'(data), 'h02);
    chk("fullrd_hits",     hits, exp_hits);
    for (int i = 0; i < 16; i++) pop();
    chk("fullrd_drained",  int'(count), 0);
    chk("fullrd_q_empty",  exp_q.size(), 0);

    // 3-cycle glitch on ps2_clk while idle, with dat low.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    step(3);
    ps2_clk = 1'b1;
    step(20);
    ps2_dat = 1'b1;
    step(5);
    send_frame(8'h5A, 1'b0, 1'b0, 10, 1'b1);
    chk("glitch_count", int'(count), 1);
    chk("glitch_data",  int'(data), 'h5A);
    chk("glitch_perr",  int'(perr), 0);
    chk("glitch_ferr",  int'(ferr), 0);

    // Reset mid-frame with a byte buffered and perr set.
    send_frame(8'h07, 1'b1, 1'b0, 10, 1'b0);
    chk("pre_rst_perr", int'(perr), 1);
    send_bit(1'b0, 10);
    send_bit(1'b1, 10);
    send_bit(1'b1, 10);
    reset = 1'b1;
    step(2);
    chk_reset_vals("midrst");
    reset = 1'b0;
    exp_q.delete();
    step(2);
    send_frame(8'h33, 1'b0, 1'b0, 10, 1'b1);
    chk("post_rst_data",  int'(data), 'h33);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_perr",  int'(perr), 0);
    chk("post_rst_ferr",  int'(ferr), 0);
    pop();
    chk("final_hits", hits, exp_hits);
    chk("final_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
